// File: rtl/audio_i2s_stream_if_if.sv
// ----------------------------------------------------------------------------
// audio_i2s_stream_if_if
// Streaming side of the codec audio interface: stereo {left, right} frames.
//   adc_data / adc_valid / adc_ready : captured ADC frames towards the fabric
//   dac_data / dac_valid / dac_ready : DAC frames from the fabric
// Modports:
//   slave  : the audio interface block (sources ADC frames, sinks DAC frames)
//   master : the fabric side (consumes ADC frames, produces DAC frames)
// ----------------------------------------------------------------------------
interface audio_i2s_stream_if_if #(
    parameter int DATA_WIDTH = 16
);
    logic [2*DATA_WIDTH-1:0] adc_data;
    logic                    adc_valid;
    logic                    adc_ready;
    logic [2*DATA_WIDTH-1:0] dac_data;
    logic                    dac_valid;
    logic                    dac_ready;

    modport slave (
        output adc_data, adc_valid, dac_ready,
        input  adc_ready, dac_data, dac_valid
    );

    modport master (
        input  adc_data, adc_valid, dac_ready,
        output adc_ready, dac_data, dac_valid
    );
endinterface

// File: rtl/audio_i2s_stream_if.sv
// ----------------------------------------------------------------------------
// audio_i2s_stream_if
// Codec-side serial audio port (codec is bit-clock master). Deserialises ADC
// samples and serialises DAC samples, I2S or left-justified framing, with a
// stereo-frame FIFO on each direction.
// Ports:
//   clk_clk, reset_reset_n : system clock (>= 8x BCLK), async active-low reset
//   BCLK, ADCLRCK, ADCDAT  : codec ADC bus inputs (asynchronous to clk_clk)
//   DACLRCK, DACDAT        : codec DAC frame clock in, serial data out
//   strm                   : stream interface (slave modport)
//   adc_fill, dac_fill     : FIFO occupancies
//   adc_overflow           : sticky, ADC frame dropped on a full FIFO
//   dac_underflow          : sticky, DAC frame needed while FIFO empty
//   status_clear           : pulse clearing both sticky flags
// ----------------------------------------------------------------------------
module audio_i2s_stream_if #(
    parameter int DATA_WIDTH     = 16,
    parameter int FIFO_DEPTH     = 8,
    parameter int LEFT_JUSTIFIED = 0
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,
    input  logic                        BCLK,
    input  logic                        ADCLRCK,
    input  logic                        ADCDAT,
    input  logic                        DACLRCK,
    output logic                        DACDAT,
    audio_i2s_stream_if_if.slave        strm,
    output logic [$clog2(FIFO_DEPTH):0] adc_fill,
    output logic [$clog2(FIFO_DEPTH):0] dac_fill,
    output logic                        adc_overflow,
    output logic                        dac_underflow,
    input  logic                        status_clear
);
    localparam int FW = 2 * DATA_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam bit LJ = (LEFT_JUSTIFIED != 0);

    // ---------------- synchronisers and edge detection ----------------
    // bit 0 BCLK, bit 1 ADCLRCK, bit 2 DACLRCK, bit 3 ADCDAT (level only)
    logic [3:0] sync1_reg, sync2_reg;
    logic [2:0] sync3_reg;
    logic [2:0] rise, fall;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            sync3_reg <= '0;
        end else begin
            sync1_reg <= {ADCDAT, DACLRCK, ADCLRCK, BCLK};
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg[2:0];
        end
    end

    assign rise = sync2_reg[2:0] & ~sync3_reg;
    assign fall = ~sync2_reg[2:0] & sync3_reg;

    logic bclk_rise, bclk_fall, adc_lr_edge, adc_lr_lvl, dac_lr_rise, dac_lr_fall, adc_bit;
    assign bclk_rise   = rise[0];
    assign bclk_fall   = fall[0];
    assign adc_lr_edge = rise[1] | fall[1];
    assign adc_lr_lvl  = sync2_reg[1];
    assign dac_lr_rise = rise[2];
    assign dac_lr_fall = fall[2];
    assign adc_bit     = sync2_reg[3];

    // ---------------- FIFOs: index 0 = ADC, 1 = DAC ----------------
    logic [1:0]    fifo_push, fifo_pop;
    logic [FW-1:0] fifo_wdata [2];
    logic [FW-1:0] fifo_head  [2];
    logic [CW-1:0] fifo_count [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [FW-1:0] mem [FIFO_DEPTH];
            logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
            logic [CW-1:0] count_reg;
            logic          do_push, do_pop;

            // Full/empty come from the registered count only, so a push to a
            // full FIFO is lost even with a simultaneous pop, and a pop from
            // an empty FIFO returns zeros even with a simultaneous push.
            assign do_push = fifo_push[gi] && (count_reg != CW'(FIFO_DEPTH));
            assign do_pop  = fifo_pop[gi] && (count_reg != '0);

            always_ff @(posedge clk_clk) begin
                if (do_push) mem[wr_ptr_reg] <= fifo_wdata[gi];
            end

            always_ff @(posedge clk_clk or negedge reset_reset_n) begin
                if (!reset_reset_n) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
                end
            end

            // Head is read combinationally so it is valid the cycle the count
            // becomes non-zero; zeros whenever the FIFO is empty.
            assign fifo_head[gi]  = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
            assign fifo_count[gi] = count_reg;
        end
    endgenerate

    // ---------------- ADC deserialiser ----------------
    typedef enum logic [1:0] {ADC_IDLE, ADC_SKIP, ADC_SHIFT, ADC_DONE} adc_state_t;

    adc_state_t            adc_state_reg, adc_state_next;
    logic [BW-1:0]         adc_cnt_reg, adc_cnt_next;
    logic [DATA_WIDTH-1:0] adc_sr_reg, adc_sr_next, adc_sr_shift;
    logic [DATA_WIDTH-1:0] adc_left_reg, adc_left_next;
    logic                  adc_right_reg, adc_right_next;
    logic                  adc_left_ok_reg, adc_left_ok_next;
    logic                  adc_push;

    assign adc_sr_shift = {adc_sr_reg[DATA_WIDTH-2:0], adc_bit};

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            adc_state_reg   <= ADC_IDLE;
            adc_cnt_reg     <= '0;
            adc_sr_reg      <= '0;
            adc_left_reg    <= '0;
            adc_right_reg   <= 1'b0;
            adc_left_ok_reg <= 1'b0;
        end else begin
            adc_state_reg   <= adc_state_next;
            adc_cnt_reg     <= adc_cnt_next;
            adc_sr_reg      <= adc_sr_next;
            adc_left_reg    <= adc_left_next;
            adc_right_reg   <= adc_right_next;
            adc_left_ok_reg <= adc_left_ok_next;
        end
    end

    // adc_left_ok marks a complete left channel in the current frame. Only a
    // right channel that follows one is pushed, so frames cut by reset or by a
    // premature LRCK edge never reach the FIFO.
    always_comb begin
        adc_state_next   = adc_state_reg;
        adc_cnt_next     = adc_cnt_reg;
        adc_sr_next      = adc_sr_reg;
        adc_left_next    = adc_left_reg;
        adc_right_next   = adc_right_reg;
        adc_left_ok_next = adc_left_ok_reg;
        adc_push         = 1'b0;
        if (adc_lr_edge) begin
            adc_state_next = LJ ? ADC_SHIFT : ADC_SKIP;
            adc_cnt_next   = '0;
            adc_sr_next    = '0;
            adc_right_next = adc_lr_lvl;
            if (!adc_lr_lvl) adc_left_ok_next = 1'b0;
        end else if (bclk_rise) begin
            case (adc_state_reg)
                ADC_SKIP: adc_state_next = ADC_SHIFT;
                ADC_SHIFT: begin
                    adc_sr_next  = adc_sr_shift;
                    adc_cnt_next = adc_cnt_reg + 1'b1;
                    if (adc_cnt_reg == BW'(DATA_WIDTH - 1)) begin
                        adc_state_next = ADC_DONE;
                        if (adc_right_reg) begin
                            adc_push         = adc_left_ok_reg;
                            adc_left_ok_next = 1'b0;
                        end else begin
                            adc_left_next    = adc_sr_shift;
                            adc_left_ok_next = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- DAC serialiser ----------------
    logic [DATA_WIDTH-1:0] dac_sr_reg, dac_sr_next;
    logic [DATA_WIDTH-1:0] dac_right_hold_reg, dac_right_hold_next;
    logic [DATA_WIDTH-1:0] dac_load_word;
    logic [BW-1:0]         dac_cnt_reg, dac_cnt_next;
    logic                  dac_out_reg, dac_out_next;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            dac_sr_reg         <= '0;
            dac_right_hold_reg <= '0;
            dac_cnt_reg        <= '0;
            dac_out_reg        <= 1'b0;
        end else begin
            dac_sr_reg         <= dac_sr_next;
            dac_right_hold_reg <= dac_right_hold_next;
            dac_cnt_reg        <= dac_cnt_next;
            dac_out_reg        <= dac_out_next;
        end
    end

    // dac_cnt counts bits still to be driven. Left-justified puts the MSB out
    // on the LRCK edge itself; I2S waits for the next BCLK fall.
    always_comb begin
        dac_sr_next         = dac_sr_reg;
        dac_right_hold_next = dac_right_hold_reg;
        dac_cnt_next        = dac_cnt_reg;
        dac_out_next        = dac_out_reg;
        dac_load_word       = '0;
        if (dac_lr_fall || dac_lr_rise) begin
            if (dac_lr_fall) begin
                dac_load_word       = fifo_head[1][FW-1:DATA_WIDTH];
                dac_right_hold_next = fifo_head[1][DATA_WIDTH-1:0];
            end else begin
                dac_load_word = dac_right_hold_reg;
            end
            if (LJ) begin
                dac_out_next = dac_load_word[DATA_WIDTH-1];
                dac_sr_next  = {dac_load_word[DATA_WIDTH-2:0], 1'b0};
                dac_cnt_next = BW'(DATA_WIDTH - 1);
            end else begin
                dac_sr_next  = dac_load_word;
                dac_cnt_next = BW'(DATA_WIDTH);
            end
        end else if (bclk_fall) begin
            if (dac_cnt_reg != '0) begin
                dac_out_next = dac_sr_reg[DATA_WIDTH-1];
                dac_sr_next  = {dac_sr_reg[DATA_WIDTH-2:0], 1'b0};
                dac_cnt_next = dac_cnt_reg - 1'b1;
            end else begin
                dac_out_next = 1'b0;
            end
        end
    end

    assign DACDAT = dac_out_reg;

    // ---------------- streaming and status ----------------
    assign fifo_push[0]  = adc_push;
    assign fifo_wdata[0] = {adc_left_reg, adc_sr_shift};
    assign fifo_pop[0]   = strm.adc_valid && strm.adc_ready;
    assign fifo_push[1]  = strm.dac_valid && strm.dac_ready;
    assign fifo_wdata[1] = strm.dac_data;
    assign fifo_pop[1]   = dac_lr_fall;

    assign strm.adc_valid = (fifo_count[0] != '0);
    assign strm.adc_data  = fifo_head[0];
    assign strm.dac_ready = (fifo_count[1] != CW'(FIFO_DEPTH));
    assign adc_fill       = fifo_count[0];
    assign dac_fill       = fifo_count[1];

    logic adc_drop, dac_starve;
    assign adc_drop   = fifo_push[0] && (fifo_count[0] == CW'(FIFO_DEPTH));
    assign dac_starve = fifo_pop[1] && (fifo_count[1] == '0);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            adc_overflow  <= 1'b0;
            dac_underflow <= 1'b0;
        end else begin
            if (adc_drop)          adc_overflow <= 1'b1;
            else if (status_clear) adc_overflow <= 1'b0;
            if (dac_starve)        dac_underflow <= 1'b1;
            else if (status_clear) dac_underflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_audio_i2s_stream_if.sv
// ----------------------------------------------------------------------------
// tb_audio_i2s_stream_if
// Directed bench: one I2S instance (FIFO_DEPTH=4) and one left-justified
// instance (FIFO_DEPTH=8) share a behavioural codec driving BCLK (8x slower
// than clk_clk), the LRCKs and ADCDAT. Each half-frame is 24 BCLKs.
// ----------------------------------------------------------------------------
module tb_audio_i2s_stream_if;
    localparam int W  = 16;
    localparam int HB = 24;

    logic clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    logic reset_reset_n, BCLK, ADCLRCK, ADCDAT, DACLRCK, status_clear;
    logic dacdat_i2s, dacdat_lj;
    logic [2:0] adc_fill_i2s, dac_fill_i2s;
    logic [3:0] adc_fill_lj, dac_fill_lj;
    logic ovf_i2s, unf_i2s, ovf_lj, unf_lj;

    audio_i2s_stream_if_if #(.DATA_WIDTH(W)) strm_i2s ();
    audio_i2s_stream_if_if #(.DATA_WIDTH(W)) strm_lj ();

    audio_i2s_stream_if #(.DATA_WIDTH(W), .FIFO_DEPTH(4), .LEFT_JUSTIFIED(0)) u_dut_i2s (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .BCLK(BCLK), .ADCLRCK(ADCLRCK), .ADCDAT(ADCDAT),
        .DACLRCK(DACLRCK), .DACDAT(dacdat_i2s), .strm(strm_i2s),
        .adc_fill(adc_fill_i2s), .dac_fill(dac_fill_i2s),
        .adc_overflow(ovf_i2s), .dac_underflow(unf_i2s),
        .status_clear(status_clear)
    );

    audio_i2s_stream_if #(.DATA_WIDTH(W), .FIFO_DEPTH(8), .LEFT_JUSTIFIED(1)) u_dut_lj (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .BCLK(BCLK), .ADCLRCK(ADCLRCK), .ADCDAT(ADCDAT),
        .DACLRCK(DACLRCK), .DACDAT(dacdat_lj), .strm(strm_lj),
        .adc_fill(adc_fill_lj), .dac_fill(dac_fill_lj),
        .adc_overflow(ovf_lj), .dac_underflow(unf_lj),
        .status_clear(status_clear)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [15:0] cap_i2s_l, cap_i2s_r, cap_lj_l, cap_lj_r;
    logic        stray_i2s, stray_lj;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_value({tag, "_adc_valid"}, 64'(strm_i2s.adc_valid), 64'(0));
        check_value({tag, "_adc_data"},  64'(strm_i2s.adc_data),  64'(0));
        check_value({tag, "_adc_fill"},  64'(adc_fill_i2s),       64'(0));
        check_value({tag, "_dac_fill"},  64'(dac_fill_i2s),       64'(0));
        check_value({tag, "_dac_ready"}, 64'(strm_i2s.dac_ready), 64'(1));
        check_value({tag, "_overflow"},  64'(ovf_i2s),            64'(0));
        check_value({tag, "_underflow"}, 64'(unf_i2s),            64'(0));
        check_value({tag, "_dacdat"},    64'(dacdat_i2s),         64'(0));
        check_value({tag, "_dacdat_lj"}, 64'(dacdat_lj),          64'(0));
    endtask

    // One LRCK half-frame. Data and LRCK change on the BCLK fall; DACDAT is
    // sampled just before the BCLK rise. I2S word bits sit at BCLK 1..16,
    // left-justified at BCLK 0..15.
    task automatic send_half(input logic lr, input logic [15:0] w, input int rst_at, input bit clr_last);
        logic [15:0] ci, cl;
        ci = '0;
        cl = '0;
        for (int i = 0; i < HB; i++) begin
            BCLK    = 1'b0;
            ADCLRCK = lr;
            DACLRCK = lr;
            ADCDAT  = (i >= 1 && i <= 16) ? w[16-i] : 1'b0;
            if (rst_at >= 0 && i == rst_at)     reset_reset_n = 1'b0;
            if (rst_at >= 0 && i == rst_at + 4) reset_reset_n = 1'b1;
            #38;
            if (i >= 1 && i <= 16) ci[16-i] = dacdat_i2s;
            else                   stray_i2s |= dacdat_i2s;
            if (i <= 15) cl[15-i] = dacdat_lj;
            else         stray_lj |= dacdat_lj;
            if (rst_at >= 0 && i == rst_at) check_reset_state("rst_mid");
            #2;
            BCLK = 1'b1;
            if (clr_last && i == 16) begin
                // lands on the clock edge where the last-bit capture registers
                #20 status_clear = 1'b1;
                #10 status_clear = 1'b0;
                #10;
            end else begin
                #40;
            end
        end
        if (lr) begin
            cap_i2s_r = ci;
            cap_lj_r  = cl;
        end else begin
            cap_i2s_l = ci;
            cap_lj_l  = cl;
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input bit clr_last);
        stray_i2s = 1'b0;
        stray_lj  = 1'b0;
        send_half(1'b0, l, -1, 1'b0);
        send_half(1'b1, r, -1, clr_last);
    endtask

    task automatic push_dac_i2s(input logic [31:0] f);
        @(negedge clk_clk);
        strm_i2s.dac_data  = f;
        strm_i2s.dac_valid = 1'b1;
        @(negedge clk_clk);
        strm_i2s.dac_valid = 1'b0;
    endtask

    task automatic push_dac_lj(input logic [31:0] f);
        @(negedge clk_clk);
        strm_lj.dac_data  = f;
        strm_lj.dac_valid = 1'b1;
        @(negedge clk_clk);
        strm_lj.dac_valid = 1'b0;
    endtask

    task automatic pop_adc_i2s();
        @(negedge clk_clk);
        strm_i2s.adc_ready = 1'b1;
        @(negedge clk_clk);
        strm_i2s.adc_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk_clk);
        status_clear = 1'b1;
        @(negedge clk_clk);
        status_clear = 1'b0;
    endtask

    initial begin
        logic [15:0] el, er;
        reset_reset_n = 1'b0;
        BCLK = 1'b1; ADCLRCK = 1'b1; DACLRCK = 1'b1; ADCDAT = 1'b0; status_clear = 1'b0;
        strm_i2s.adc_ready = 1'b0; strm_i2s.dac_valid = 1'b0; strm_i2s.dac_data = '0;
        strm_lj.adc_ready  = 1'b1; strm_lj.dac_valid  = 1'b0; strm_lj.dac_data  = '0;
        #20 check_reset_state("rst");
        #10 reset_reset_n = 1'b1;
        #40;

        // First frame: ADC capture, DAC FIFO empty -> zeros and underflow.
        send_frame(16'hA5C3, 16'h1234, 1'b0);
        check_value("adc1_valid", 64'(strm_i2s.adc_valid), 64'(1));
        check_value("adc1_fill",  64'(adc_fill_i2s),       64'(1));
        check_value("adc1_data",  64'(strm_i2s.adc_data),  64'h0000_0000_A5C3_1234);
        check_value("unf_i2s_dacdat", 64'({cap_i2s_l, cap_i2s_r, stray_i2s}), 64'(0));
        check_value("unf_lj_dacdat",  64'({cap_lj_l, cap_lj_r, stray_lj}),    64'(0));
        check_value("unf_i2s_flag", 64'(unf_i2s), 64'(1));
        check_value("unf_lj_flag",  64'(unf_lj),  64'(1));
        pulse_clear();
        check_value("clr_unf_i2s", 64'(unf_i2s), 64'(0));
        check_value("clr_unf_lj",  64'(unf_lj),  64'(0));
        pop_adc_i2s();
        check_value("adc1_pop_fill",  64'(adc_fill_i2s),       64'(0));
        check_value("adc1_pop_valid", 64'(strm_i2s.adc_valid), 64'(0));

        // Second frame: DAC playback in both framings.
        push_dac_lj(32'h8001_0FF0);
        push_dac_i2s(32'h1357_9BDF);
        check_value("dac_fill_lj",  64'(dac_fill_lj),  64'(1));
        check_value("dac_fill_i2s", 64'(dac_fill_i2s), 64'(1));
        send_frame(16'h0001, 16'hFFFF, 1'b0);
        check_value("lj_dac_word",  64'({cap_lj_l, cap_lj_r}),   64'h8001_0FF0);
        check_value("lj_dac_gap",   64'(stray_lj),               64'(0));
        check_value("i2s_dac_word", 64'({cap_i2s_l, cap_i2s_r}), 64'h1357_9BDF);
        check_value("i2s_dac_gap",  64'(stray_i2s),              64'(0));
        check_value("no_unf_lj",    64'(unf_lj),                 64'(0));
        check_value("dac_drain_lj", 64'(dac_fill_lj),            64'(0));
        check_value("adc2_data",    64'(strm_i2s.adc_data),      64'h0000_0000_0001_FFFF);
        pop_adc_i2s();

        // Overflow: four frames fill the FIFO, the fifth is dropped while a
        // status_clear pulse coincides with the drop.
        for (int k = 1; k <= 4; k++) begin
            el = 16'h1000 + 16'(k);
            er = 16'h2000 + 16'(k);
            send_frame(el, er, 1'b0);
        end
        check_value("ovf_fill4",    64'(adc_fill_i2s), 64'(4));
        check_value("ovf_before",   64'(ovf_i2s),      64'(0));
        check_value("full_valid",   64'(strm_i2s.adc_valid), 64'(1));
        send_frame(16'h1005, 16'h2005, 1'b1);
        check_value("ovf_fill_after", 64'(adc_fill_i2s), 64'(4));
        check_value("ovf_vs_clear",   64'(ovf_i2s),      64'(1));
        for (int k = 1; k <= 4; k++) begin
            el = 16'h1000 + 16'(k);
            er = 16'h2000 + 16'(k);
            check_value($sformatf("ovf_pop%0d", k), 64'(strm_i2s.adc_data), 64'({el, er}));
            pop_adc_i2s();
        end
        check_value("ovf_empty", 64'(adc_fill_i2s), 64'(0));

        // Reset during the 8th left bit clears everything; the cut frame is
        // never pushed and the following frame is captured intact.
        send_frame(16'h7777, 16'h8888, 1'b0);
        push_dac_i2s(32'hDEAD_BEEF);
        push_dac_i2s(32'hCAFE_F00D);
        check_value("pre_rst_adc_fill", 64'(adc_fill_i2s), 64'(1));
        check_value("pre_rst_dac_fill", 64'(dac_fill_i2s), 64'(2));
        stray_i2s = 1'b0;
        stray_lj  = 1'b0;
        send_half(1'b0, 16'h5A5A, 8, 1'b0);
        send_half(1'b1, 16'hC3C3, -1, 1'b0);
        check_value("post_rst_no_partial", 64'(adc_fill_i2s),       64'(0));
        check_value("post_rst_valid",      64'(strm_i2s.adc_valid), 64'(0));
        send_frame(16'h5A5A, 16'hC3C3, 1'b0);
        check_value("recover_fill", 64'(adc_fill_i2s),      64'(1));
        check_value("recover_data", 64'(strm_i2s.adc_data), 64'h0000_0000_5A5A_C3C3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
